// File: rtl/vga_pkg.sv
// vga_pkg: region encodings, read FSM states and write FIFO entry layout for vga_bus_bridge
package vga_pkg;

   typedef enum logic [1:0] {
      REG_TEXT   = 2'b00,
      REG_GRAPH  = 2'b01,
      REG_CURSOR = 2'b10,
      REG_CTRL   = 2'b11
   } region_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } rd_state_t;

   typedef struct packed {
      region_t     region;
      logic [15:0] offset;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_entry_t;

   localparam int ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/vga_wr_fifo.sv
// vga_wr_fifo: posted-write FIFO, DEPTH entries (power of two), pointers carry an extra wrap bit
module vga_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 54
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // advance pointers on accepted push/pop; storage itself is not reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/vga_bus_bridge.sv
// vga_bus_bridge: CPU to VGA controller bridge with posted writes and blocking reads; VGA_BRIDGE_BUSY_THROTTLE_EN holds accesses while vga_busy
module vga_bus_bridge
   import vga_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_sel,
   input  logic [31:0] cpu_addr,
   input  logic [3:0]  cpu_we,
   input  logic        cpu_rd,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic [3:0]  we_text,
   output logic [3:0]  we_graph,
   output logic [3:0]  we_cursor,
   output logic [3:0]  we_reg,
   output logic        rd_text,
   output logic        rd_graph,
   output logic        rd_cursor,
   output logic        rd_reg,
   output logic [31:0] text_addr,
   output logic [31:0] graph_addr,
   output logic [31:0] text_wdata,
   output logic [31:0] graph_wdata,
   output logic [31:0] cursor_wdata,
   output logic [31:0] reg_wdata,
   input  logic [31:0] text_rdata,
   input  logic [31:0] graph_rdata,
   input  logic [31:0] cursor_rdata,
   input  logic [31:0] reg_rdata,
   input  logic        vga_busy
);

   rd_state_t   state, state_n;
   region_t     rreg_q, cur_reg;
   logic [15:0] roff_q, cur_off;
   logic [15:0] addr_q;
   logic [31:0] wdata_q, rdata_q, sel_rdata;
   logic        wr_req, rd_req, push, pop, full, empty, can_go, issue;
   wr_entry_t   wr_entry, head;
   logic        unused_bits;

   assign unused_bits = ^{cpu_addr[31:18], vga_busy};

`ifdef VGA_BRIDGE_BUSY_THROTTLE_EN
   assign can_go = !vga_busy;
`else
   assign can_go = 1'b1;
`endif

   assign wr_req    = cpu_sel & |cpu_we;
   assign rd_req    = cpu_sel & cpu_rd & ~|cpu_we;
   assign push      = wr_req & ~full;
   assign pop       = ~empty & can_go;
   assign wr_entry  = '{region: region_t'(cpu_addr[17:16]), offset: cpu_addr[15:0], be: cpu_we, data: cpu_wdata};
   assign cur_reg   = state == S_IDLE ? region_t'(cpu_addr[17:16]) : rreg_q;
   assign cur_off   = state == S_IDLE ? cpu_addr[15:0] : roff_q;
   assign issue     = state_n == S_ISSUE;
   assign sel_rdata = rreg_q == REG_TEXT   ? text_rdata   :
                      rreg_q == REG_GRAPH  ? graph_rdata  :
                      rreg_q == REG_CURSOR ? cursor_rdata : reg_rdata;

   assign cpu_stall    = (wr_req & full) | (rd_req & (state != S_DONE));
   assign cpu_rdata    = rdata_q;
   assign text_addr    = {16'b0, addr_q};
   assign graph_addr   = {16'b0, addr_q};
   assign text_wdata   = wdata_q;
   assign graph_wdata  = wdata_q;
   assign cursor_wdata = wdata_q;
   assign reg_wdata    = wdata_q;

   vga_wr_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // read FSM next state: drain posted writes before issuing the read
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (rd_req) state_n = !empty ? S_DRAIN : can_go ? S_ISSUE : S_IDLE;
         S_DRAIN: if (empty && can_go) state_n = S_ISSUE;
         S_ISSUE: state_n = S_WAIT;
         S_WAIT:  state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // state, latched read request, registered controller strobes and read data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rreg_q    <= REG_TEXT;
         roff_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_text   <= '0;
         we_graph  <= '0;
         we_cursor <= '0;
         we_reg    <= '0;
         rd_text   <= 1'b0;
         rd_graph  <= 1'b0;
         rd_cursor <= 1'b0;
         rd_reg    <= 1'b0;
      end else begin
         state     <= state_n;
         we_text   <= (pop && head.region == REG_TEXT)   ? head.be : 4'h0;
         we_graph  <= (pop && head.region == REG_GRAPH)  ? head.be : 4'h0;
         we_cursor <= (pop && head.region == REG_CURSOR) ? head.be : 4'h0;
         we_reg    <= (pop && head.region == REG_CTRL)   ? head.be : 4'h0;
         rd_text   <= issue && cur_reg == REG_TEXT;
         rd_graph  <= issue && cur_reg == REG_GRAPH;
         rd_cursor <= issue && cur_reg == REG_CURSOR;
         rd_reg    <= issue && cur_reg == REG_CTRL;
         if (state == S_IDLE && rd_req) begin
            rreg_q <= cur_reg;
            roff_q <= cpu_addr[15:0];
         end
         if (pop) begin
            addr_q  <= head.offset;
            wdata_q <= head.data;
         end else if (issue) begin
            addr_q <= cur_off;
         end
         if (state == S_WAIT)
            rdata_q <= sel_rdata;
      end
   end

endmodule

// File: tb/tb_vga_bus_bridge.sv
// tb_vga_bus_bridge: scoreboard bench for vga_bus_bridge; covers VGA_BRIDGE_BUSY_THROTTLE_EN builds too
module tb_vga_bus_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_sel = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [3:0]  cpu_we = '0;
   logic        cpu_rd = 1'b0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic [3:0]  we_text, we_graph, we_cursor, we_reg;
   logic        rd_text, rd_graph, rd_cursor, rd_reg;
   logic [31:0] text_addr, graph_addr;
   logic [31:0] text_wdata, graph_wdata, cursor_wdata, reg_wdata;
   logic [31:0] text_rdata = '0, graph_rdata = '0, cursor_rdata = '0, reg_rdata = '0;
   logic        vga_busy = 1'b0;

   typedef struct {
      logic [1:0]  region;
      logic [15:0] off;
      logic [3:0]  be;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        m_e;
   logic [15:0] m_ev;
   logic [31:0] mem [4][64];
   int          n_pass = 0;
   int          n_total = 0;

   vga_bus_bridge #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
      .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .we_text(we_text), .we_graph(we_graph), .we_cursor(we_cursor), .we_reg(we_reg),
      .rd_text(rd_text), .rd_graph(rd_graph), .rd_cursor(rd_cursor), .rd_reg(rd_reg),
      .text_addr(text_addr), .graph_addr(graph_addr),
      .text_wdata(text_wdata), .graph_wdata(graph_wdata), .cursor_wdata(cursor_wdata), .reg_wdata(reg_wdata),
      .text_rdata(text_rdata), .graph_rdata(graph_rdata), .cursor_rdata(cursor_rdata), .reg_rdata(reg_rdata),
      .vga_busy(vga_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
      return o;
   endfunction

   // controller model: byte-enabled register file, one-cycle read latency, poison when not read
   always @(posedge clk) begin
      if (|we_text)   mem[0][text_addr[7:2]] <= merge(mem[0][text_addr[7:2]], text_wdata, we_text);
      if (|we_graph)  mem[1][text_addr[7:2]] <= merge(mem[1][text_addr[7:2]], graph_wdata, we_graph);
      if (|we_cursor) mem[2][text_addr[7:2]] <= merge(mem[2][text_addr[7:2]], cursor_wdata, we_cursor);
      if (|we_reg)    mem[3][text_addr[7:2]] <= merge(mem[3][text_addr[7:2]], reg_wdata, we_reg);
      text_rdata   <= rd_text   ? mem[0][text_addr[7:2]] : 32'hDEAD_0000;
      graph_rdata  <= rd_graph  ? mem[1][text_addr[7:2]] : 32'hDEAD_0001;
      cursor_rdata <= rd_cursor ? mem[2][text_addr[7:2]] : 32'hDEAD_0002;
      reg_rdata    <= rd_reg    ? mem[3][text_addr[7:2]] : 32'hDEAD_0003;
   end

   // scoreboard: every write strobe must match the oldest accepted write
   always @(negedge clk) begin
      if (!rst && |{we_text, we_graph, we_cursor, we_reg}) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL strobe_unexpected: got we=%h addr=%h data=%h, expected no strobe",
                     {we_text, we_graph, we_cursor, we_reg}, text_addr, text_wdata);
         end else begin
            m_e  = exp_q.pop_front();
            m_ev = {12'h0, m_e.be} << (4 * (3 - int'(m_e.region)));
            if ({we_text, we_graph, we_cursor, we_reg} !== m_ev || text_addr !== {16'h0, m_e.off} ||
                graph_addr !== {16'h0, m_e.off} || text_wdata !== m_e.data || graph_wdata !== m_e.data ||
                cursor_wdata !== m_e.data || reg_wdata !== m_e.data)
               $display("FAIL strobe_order: got we=%h addr=%h data=%h, expected we=%h addr=%h data=%h",
                        {we_text, we_graph, we_cursor, we_reg}, text_addr, text_wdata, m_ev, m_e.off, m_e.data);
            else
               n_pass++;
         end
      end
   end

   task automatic idle();
      cpu_sel = 1'b0;
      cpu_we  = 4'h0;
      cpu_rd  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, output int waits);
      exp_t e;
      cpu_sel = 1'b1; cpu_rd = 1'b0; cpu_addr = a; cpu_we = be; cpu_wdata = d;
      e.region = a[17:16]; e.off = a[15:0]; e.be = be; e.data = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            exp_q.push_back(e);
            waits = i;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      waits = 100;
      n_total++;
      $display("FAIL write_timeout: addr=%h still stalled after 100 cycles, expected acceptance", a);
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp_data, input int exp_cyc);
      int         cyc, nrd, rd_cyc;
      logic [3:0] rv, exp_rv;
      logic [3:0] one = 4'b1000;
      exp_rv = one >> a[17:16];
      cpu_sel = 1'b1; cpu_we = 4'h0; cpu_rd = 1'b1; cpu_addr = a;
      cyc = 0; nrd = 0; rd_cyc = -1; rv = 4'h0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (|{rd_text, rd_graph, rd_cursor, rd_reg}) begin
            nrd++; rd_cyc = cyc; rv = {rd_text, rd_graph, rd_cursor, rd_reg};
         end
         if (!cpu_stall) break;
         @(posedge clk); #1;
         cyc++;
      end
      n_total++;
      if (cyc !== exp_cyc) $display("FAIL %s_latency: stall dropped in cycle %0d, expected %0d", name, cyc, exp_cyc);
      else n_pass++;
      n_total++;
      if (cpu_rdata !== exp_data) $display("FAIL %s_data: cpu_rdata=%h, expected %h", name, cpu_rdata, exp_data);
      else n_pass++;
      n_total++;
      if (nrd !== 1 || rd_cyc !== exp_cyc - 2 || rv !== exp_rv)
         $display("FAIL %s_rd_strobe: %0d pulses, cycle %0d, vector %b, expected 1 pulse in cycle %0d vector %b",
                  name, nrd, rd_cyc, rv, exp_cyc - 2, exp_rv);
      else n_pass++;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL %s_drain: %0d writes never strobed, expected 0", name, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({we_text, we_graph, we_cursor, we_reg, rd_text, rd_graph, rd_cursor, rd_reg} !== 20'h0)
         $display("FAIL reset_strobes: got %h, expected 0", {we_text, we_graph, we_cursor, we_reg, rd_text, rd_graph, rd_cursor, rd_reg});
      else n_pass++;
      n_total++;
      if (text_addr !== 0 || graph_addr !== 0 || text_wdata !== 0 || graph_wdata !== 0 || cursor_wdata !== 0 || reg_wdata !== 0)
         $display("FAIL reset_paths: addr=%h wdata=%h, expected 0", text_addr, text_wdata);
      else n_pass++;
      n_total++;
      if (cpu_rdata !== 0 || cpu_stall !== 1'b0)
         $display("FAIL reset_cpu: rdata=%h stall=%b, expected 0 and 0", cpu_rdata, cpu_stall);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      int w;
      wr(32'h0001_0010, 4'hF, 32'h0000_ABCD, w);
      idle();
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if ({we_text, we_graph, we_cursor, we_reg} !== 16'h0F00)
         $display("FAIL single_we: got %h, expected 0f00", {we_text, we_graph, we_cursor, we_reg});
      else n_pass++;
      n_total++;
      if (graph_addr !== 32'h10 || graph_wdata !== 32'hABCD)
         $display("FAIL single_addr_data: addr=%h data=%h, expected 10 and abcd", graph_addr, graph_wdata);
      else n_pass++;
      wait_drain("single");
   endtask

   task automatic test_read_empty();
      rd("read_empty", 32'h0000_0020, 32'h0000_1234, 3);
   endtask

   task automatic test_read_after_write();
      int w;
      wr(32'h0003_0004, 4'hF, 32'h0000_0055, w);
      rd("read_after_write", 32'h0003_0004, 32'h0000_0055, 4);
      wait_drain("raw");
   endtask

   task automatic test_back_to_back();
      int w, maxw;
      maxw = 0;
      for (int i = 0; i < 6; i++) begin
         wr({14'h0, 2'(i % 4), 16'(8'h80 + 4 * i)}, (i % 2 == 0) ? 4'hF : 4'h3, 32'hB2B0_0000 + 32'(i), w);
         if (w > maxw) maxw = w;
      end
      idle();
      n_total++;
      if (maxw != 0) $display("FAIL b2b_no_stall: waited %0d cycles, expected 0", maxw);
      else n_pass++;
      wait_drain("b2b");
      rd("b2b_readback", 32'h0001_0094, 32'h0000_0005, 3);
   endtask

   task automatic test_wrap();
      int w;
      for (int i = 0; i < 9; i++) begin
         wr({14'h0, 2'(i % 4), 16'(8'h40 + 4 * i)}, (i % 2 == 0) ? 4'hF : 4'h3, 32'hC0DE_0000 + 32'(i), w);
         idle();
         @(posedge clk); #1;
      end
      wait_drain("wrap");
      rd("wrap_empty", 32'h0000_0060, 32'hC0DE_0008, 3);
   endtask

`ifdef VGA_BRIDGE_BUSY_THROTTLE_EN
   task automatic test_full();
      int   w;
      exp_t e;
      vga_busy = 1'b1;
      for (int i = 0; i < 4; i++) wr({14'h0, 2'(i), 16'(4 * i)}, 4'hF, 32'hF000_0000 + 32'(i), w);
      cpu_sel = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h0002_0030; cpu_wdata = 32'hF000_0004;
      e.region = 2'd2; e.off = 16'h30; e.be = 4'hF; e.data = 32'hF000_0004;
      @(negedge clk);
      n_total++;
      if (cpu_stall !== 1'b1) $display("FAIL full_stall: stall=%b, expected 1", cpu_stall);
      else n_pass++;
      @(posedge clk); #1;
      vga_busy = 1'b0;
      @(negedge clk);
      n_total++;
      if (cpu_stall !== 1'b1) $display("FAIL full_pop_cycle: stall=%b, expected 1", cpu_stall);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_total++;
      if (cpu_stall !== 1'b0) $display("FAIL full_accept: stall=%b, expected 0", cpu_stall);
      else n_pass++;
      exp_q.push_back(e);
      @(posedge clk); #1;
      idle();
      wait_drain("full");
   endtask
`else
   task automatic test_busy_ignored();
      int w;
      vga_busy = 1'b1;
      wr(32'h0002_0008, 4'h6, 32'h0066_0000, w);
      idle();
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (we_cursor !== 4'h6) $display("FAIL busy_ignored: we_cursor=%h, expected 6", we_cursor);
      else n_pass++;
      vga_busy = 1'b0;
      wait_drain("busy");
   endtask
`endif

   task automatic test_reset_mid();
      int w;
      vga_busy = 1'b1;
      for (int i = 0; i < 3; i++) wr({14'h0, 2'd1, 16'(8'hC0 + 4 * i)}, 4'hF, 32'h5EED_0000 + 32'(i), w);
      cpu_sel = 1'b1; cpu_we = 4'h0; cpu_rd = 1'b1; cpu_addr = 32'h0000_0020;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      vga_busy = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_total++;
         if ({we_text, we_graph, we_cursor, we_reg, rd_text, rd_graph, rd_cursor, rd_reg} !== 20'h0 || cpu_stall !== 1'b0)
            $display("FAIL reset_mid_quiet: cycle %0d strobes=%h stall=%b, expected 0 and 0",
                     i, {we_text, we_graph, we_cursor, we_reg, rd_text, rd_graph, rd_cursor, rd_reg}, cpu_stall);
         else n_pass++;
      end
      @(posedge clk); #1;
      rd("reset_mid_idle", 32'h0000_0020, 32'h0000_1234, 3);
   endtask

   initial begin
      for (int r = 0; r < 4; r++) for (int i = 0; i < 64; i++) mem[r][i] = 32'h0;
      mem[0][8] = 32'h0000_1234;
      test_reset();
      test_single_write();
      test_read_empty();
      test_read_after_write();
      test_back_to_back();
      test_wrap();
`ifdef VGA_BRIDGE_BUSY_THROTTLE_EN
      test_full();
`else
      test_busy_ignored();
`endif
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
